// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding a UART transmitter through a launch/arm/wait handshake
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic [7:0]            wr_data_i,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic                  flush_i,
    input  logic                  clr_ovf_i,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  overflow_o,
    output logic                  empty_o,
    output logic [7:0]            tx_data_o,
    output logic                  tx_valid_o,
    input  logic                  tx_busy_i
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [7:0]              mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     level_q, level_d;
    logic                    ovf_q, ovf_d;
    logic [7:0]              tx_data_q, tx_data_d;
    logic                    tx_valid_q, tx_valid_d;
    logic                    full;
    logic                    push;
    logic                    pop;

    // Readiness looks only at the registered level, so a same-cycle pop never frees a full FIFO.
    assign full       = (level_q == LVL_FULL);
    assign wr_ready_o = !full;
    assign push       = wr_valid_i && !full && !flush_i;

    assign level_o    = level_q;
    assign overflow_o = ovf_q;
    assign empty_o    = (level_q == '0) && (state_q == ST_IDLE);
    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;

    // Launch FSM: one-cycle strobe from IDLE, then track the transmitter's busy rise and fall.
    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        tx_valid_d = 1'b0;
        tx_data_d  = tx_data_q;
        case (state_q)
            ST_IDLE: begin
                // A flush discards the head too, so no launch is taken in that cycle.
                if ((level_q != '0) && !tx_busy_i && !flush_i) begin
                    pop        = 1'b1;
                    tx_valid_d = 1'b1;
                    tx_data_d  = mem_q[rd_ptr_q];
                    state_d    = ST_ARM;
                end
            end
            ST_ARM: begin
                if (tx_busy_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!tx_busy_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pointer, level and sticky overflow next-state; flush wins over push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
        end
        if (wr_valid_i && full) begin
            ovf_d = 1'b1;
        end else if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Control state registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
            tx_data_q  <= 8'hFF;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    // Byte storage; contents are don't-care until written, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo with a behavioural UART model
module tb_uart_tx_fifo;

    localparam int DL    = 4;
    localparam int DEPTH = 16;

    logic          clk      = 1'b0;
    logic          reset_n  = 1'b0;
    logic [7:0]    wr_data  = 8'h00;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic          flush    = 1'b0;
    logic          clr_ovf  = 1'b0;
    logic [DL:0]   level;
    logic          overflow;
    logic          empty;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_busy  = 1'b0;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;

    byte unsigned rx_q[$];
    byte unsigned exp_q[$];
    int  busy_len   = 4;
    bit  rand_busy  = 1'b0;
    bit  force_busy = 1'b0;
    bit  pend       = 1'b0;
    int  cnt        = 0;
    int  viol       = 0;
    int  peak       = 0;

    uart_tx_fifo #(.DEPTH_LOG2(DL)) dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n),
        .wr_data_i  (wr_data),
        .wr_valid_i (wr_valid),
        .wr_ready_o (wr_ready),
        .flush_i    (flush),
        .clr_ovf_i  (clr_ovf),
        .level_o    (level),
        .overflow_o (overflow),
        .empty_o    (empty),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_busy_i  (tx_busy)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // UART model: busy rises the cycle after a strobe, stays high busy_len cycles, records launched bytes.
    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            tx_busy = 1'b0;
            pend    = 1'b0;
            cnt     = 0;
        end else if (force_busy) begin
            tx_busy = 1'b1;
        end else if (pend) begin
            tx_busy = 1'b1;
            pend    = 1'b0;
            cnt     = rand_busy ? int'($urandom_range(12, 1)) : busy_len;
        end else if (cnt > 1) begin
            cnt--;
        end else begin
            cnt     = 0;
            tx_busy = 1'b0;
        end
        if (reset_n && tx_valid === 1'b1) begin
            if (tx_busy || pend) viol++;
            rx_q.push_back(tx_data);
            pend = 1'b1;
        end
        if (int'(level) > peak) peak = int'(level);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n;
        n = 0;
        while (!(empty === 1'b1 && !tx_busy && !pend) && n < bound) begin
            step();
            n++;
        end
        check(tag, 32'(n < bound), 32'd1);
    endtask

    task automatic check_seq(input string tag);
        int errs;
        errs = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= rx_q.size() || rx_q[i] != exp_q[i]) errs++;
        end
        check({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
        check({tag, "_data"}, 32'(errs), 32'd0);
    endtask

    initial begin
        int sent;
        int cyc;
        byte unsigned b;

        // Reset state
        repeat (3) step();
        check("rst_level", 32'(level), 32'd0);
        check("rst_ready", 32'(wr_ready), 32'd1);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_data", 32'(tx_data), 32'hFF);
        reset_n = 1'b1;
        step();

        // Single byte latency and single pulse
        busy_len = 160;
        rx_q.delete();
        wr_data  = 8'h55;
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        check("lat_level1", 32'(level), 32'd1);
        check("lat_valid_w1", 32'(tx_valid), 32'd0);
        step();
        check("lat_valid_w2", 32'(tx_valid), 32'd1);
        check("lat_data_w2", 32'(tx_data), 32'h55);
        step();
        check("lat_valid_w3", 32'(tx_valid), 32'd0);
        check("lat_empty_busy", 32'(empty), 32'd0);
        wait_idle("lat_drain", 400);
        check("lat_rx_len", 32'(rx_q.size()), 32'd1);
        check("lat_empty_end", 32'(empty), 32'd1);
        check("lat_data_hold", 32'(tx_data), 32'h55);

        // Back-to-back burst
        busy_len = 10;
        rx_q.delete();
        exp_q.delete();
        viol = 0;
        peak = 0;
        for (int i = 1; i <= 5; i++) begin
            wr_data  = 8'(i);
            wr_valid = 1'b1;
            exp_q.push_back(8'(i));
            step();
        end
        wr_valid = 1'b0;
        wait_idle("burst_drain", 600);
        check_seq("burst");
        check("burst_viol", 32'(viol), 32'd0);
        check("burst_peak", 32'(peak == 4 || peak == 5), 32'd1);
        check("burst_level0", 32'(level), 32'd0);

        // Fill past full with transmitter held busy
        force_busy = 1'b1;
        step();
        step();
        rx_q.delete();
        exp_q.delete();
        for (int i = 0; i < 17; i++) begin
            wr_data  = 8'(8'hA0 + i);
            wr_valid = 1'b1;
            if (i < DEPTH) exp_q.push_back(8'(8'hA0 + i));
            step();
        end
        wr_valid = 1'b0;
        check("full_level", 32'(level), 32'(DEPTH));
        check("full_ready", 32'(wr_ready), 32'd0);
        check("full_ovf", 32'(overflow), 32'd1);
        step();
        check("full_ovf_sticky", 32'(overflow), 32'd1);
        wr_data  = 8'h77;
        wr_valid = 1'b1;
        clr_ovf  = 1'b1;
        step();
        check("ovf_set_prio", 32'(overflow), 32'd1);
        check("ovf_level_kept", 32'(level), 32'(DEPTH));
        wr_valid = 1'b0;
        step();
        clr_ovf = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);
        force_busy = 1'b0;
        busy_len   = 3;
        wait_idle("full_drain", 1500);
        check_seq("full");

        // Flush during WAIT with a same-cycle write
        busy_len = 30;
        rx_q.delete();
        exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            wr_data  = 8'(8'h30 + i);
            wr_valid = 1'b1;
            step();
        end
        exp_q.push_back(8'h30);
        check("flush_pre_level", 32'(level), 32'd9);
        check("flush_pre_empty", 32'(empty), 32'd0);
        flush    = 1'b1;
        wr_data  = 8'hEE;
        step();
        flush    = 1'b0;
        wr_valid = 1'b0;
        check("flush_level", 32'(level), 32'd0);
        check("flush_ready", 32'(wr_ready), 32'd1);
        wait_idle("flush_drain", 200);
        repeat (20) step();
        check_seq("flush");
        check("flush_empty", 32'(empty), 32'd1);

        // Random traffic with pointer wrap
        rand_busy = 1'b1;
        rx_q.delete();
        exp_q.delete();
        viol = 0;
        sent = 0;
        cyc  = 0;
        while (sent < 40 && cyc < 4000) begin
            if ($urandom_range(3, 0) != 0 && wr_ready === 1'b1) begin
                b        = 8'($urandom);
                wr_data  = b;
                wr_valid = 1'b1;
                exp_q.push_back(b);
                sent++;
            end else begin
                wr_valid = 1'b0;
            end
            step();
            cyc++;
        end
        wr_valid = 1'b0;
        check("rand_sent", 32'(sent), 32'd40);
        wait_idle("rand_drain", 3000);
        check_seq("rand");
        check("rand_viol", 32'(viol), 32'd0);
        rand_busy = 1'b0;

        // Asynchronous reset while in ARM
        busy_len = 20;
        rx_q.delete();
        for (int i = 0; i < 3; i++) begin
            wr_data  = 8'(8'hC1 + i);
            wr_valid = 1'b1;
            step();
        end
        wr_valid = 1'b0;
        check("arm_pre_level", 32'(level), 32'd2);
        check("arm_pre_data", 32'(tx_data), 32'hC1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_level", 32'(level), 32'd0);
        check("arst_ready", 32'(wr_ready), 32'd1);
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_valid", 32'(tx_valid), 32'd0);
        check("arst_data", 32'(tx_data), 32'hFF);
        step();
        step();
        reset_n = 1'b1;
        repeat (30) step();
        check("arst_rx_len", 32'(rx_q.size()), 32'd1);
        check("arst_post_level", 32'(level), 32'd0);
        check("arst_post_empty", 32'(empty), 32'd1);
        check("arst_post_data", 32'(tx_data), 32'hFF);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, FIFO depth = 2**DEPTH_LOG2 bytes.
REQ-002 SHALL have CLK_I  input  1  single clock for all logic.
REQ-003 SHALL have RESET_N_I  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have WR_DATA_I  input  8  byte to enqueue.
REQ-005 SHALL have WR_VALID_I  input  1  enqueue request, one byte per cycle.
REQ-006 SHALL have WR_READY_O  output  1  high when FIFO not full.
REQ-007 SHALL have FLUSH_I  input  1  discard all queued bytes.
REQ-008 SHALL have CLR_OVF_I  input  1  clear sticky overflow flag.
REQ-009 SHALL have LEVEL_O  output  DEPTH_LOG2+1  number of queued bytes.
REQ-010 SHALL have OVERFLOW_O  output  1  sticky: write attempted while full.
REQ-011 SHALL have EMPTY_O  output  1  FIFO empty and FSM in IDLE (all bytes handed off and finished).
REQ-012 SHALL have TX_DATA_O  output  8  byte to UART transmitter.
REQ-013 SHALL have TX_VALID_O  output  1  one-cycle launch strobe to UART transmitter.
REQ-014 SHALL have TX_BUSY_I  input  1  UART transmitter busy; rises the cycle after an accepted strobe, falls after the stop bit.

Function
REQ-015 SHALL store bytes in a circular buffer with DEPTH_LOG2-bit read/write pointers wrapping modulo depth; LEVEL_O range 0..depth.
REQ-016 SHALL enqueue WR_DATA_I when WR_VALID_I && WR_READY_O && !FLUSH_I; LEVEL_O updates the following cycle.
REQ-017 SHALL derive WR_READY_O from current level (level < depth) only; a pop in the same cycle does not make a full FIFO ready.
REQ-018 SHALL set OVERFLOW_O on WR_VALID_I while WR_READY_O low, discarding the byte; set has priority over CLR_OVF_I in the same cycle.
REQ-019 SHALL implement FSM IDLE -> ARM -> WAIT -> IDLE.
REQ-020 IDLE: when level > 0 and TX_BUSY_I low, SHALL register TX_VALID_O=1 and TX_DATA_O=head byte, pop head, go ARM; strobe high exactly one cycle.
REQ-021 ARM: SHALL hold TX_VALID_O=0 and stay until TX_BUSY_I=1, then go WAIT.
REQ-022 WAIT: SHALL stay until TX_BUSY_I=0, then go IDLE; next launch no earlier than the cycle after returning to IDLE.
REQ-023 TX_DATA_O SHALL hold the last launched byte until next launch.
REQ-024 Simultaneous push and pop SHALL leave LEVEL_O unchanged and both pointers advance.
REQ-025 FLUSH_I SHALL set both pointers and level to 0 next cycle, overriding a same-cycle push and pop; the in-flight character is not aborted and FSM continues ARM/WAIT normally.
REQ-026 Combined latency: byte written to empty idle FIFO with TX_BUSY_I low SHALL produce TX_VALID_O exactly 2 cycles after the write cycle.

Reset
REQ-027 On RESET_N_I low, asynchronously: pointers 0, LEVEL_O=0, WR_READY_O=1, EMPTY_O=1, OVERFLOW_O=0, TX_VALID_O=0, TX_DATA_O=8'hFF, FSM=IDLE.
REQ-028 Reset asserted mid-transfer SHALL discard queued bytes; after release FSM starts in IDLE regardless of TX_BUSY_I.

Verification
REQ-029 Write 0x55 into empty FIFO, model UART busy for 160 cycles -> TX_VALID_O single pulse at write+2 with TX_DATA_O=0x55, EMPTY_O=1 after busy falls.
REQ-030 Burst 0x01..0x05 back-to-back -> five strobes in order 0x01..0x05, each only after TX_BUSY_I fell, LEVEL_O peaks at 4 or 5 and returns to 0.
REQ-031 DEPTH_LOG2=4, TX_BUSY_I held high, write 17 bytes -> LEVEL_O=16, WR_READY_O=0, 17th byte dropped, OVERFLOW_O=1 until CLR_OVF_I.
REQ-032 Fill 10 bytes, FLUSH_I during WAIT with same-cycle write -> LEVEL_O=0 next cycle, in-flight byte completes, no further strobes.
REQ-033 Pointer wrap: 40 bytes through depth-16 FIFO with random busy lengths -> output sequence equals input sequence, no duplicates.
REQ-034 Assert RESET_N_I low between clock edges during ARM -> outputs take reset values immediately, no strobe after release until a new write.
